// File: rtl/wb_regfile_pkg.sv
// wb_regfile shared types and constants.
// Widths, zero constants and enable encodings for the WB-side register file.
package wb_regfile_pkg;

  localparam int XLEN   = 64;
  localparam int NREG   = 32;
  localparam int ADDR_W = 5;
  localparam int HILO_W = 32;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   reg_t;
  typedef logic [HILO_W-1:0] hilo_t;

  localparam reg_t      ZERO_DWORD    = '0;
  localparam hilo_t     ZERO_WORD     = '0;
  localparam logic      WRITE_ENABLE  = 1'b1;
  localparam logic      WRITE_DISABLE = 1'b0;
  localparam logic      READ_ENABLE   = 1'b1;
  localparam reg_addr_t NOP_REG_ADDR  = '0;

endpackage

// File: rtl/wb_regfile_hilo.sv
// HI/LO pair storage with same-cycle writeback bypass.
// HI and LO always update together under one enable.
module hilo_reg
  import wb_regfile_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  we,
  input  hilo_t hi,
  input  hilo_t lo,
  output hilo_t hi_o,
  output hilo_t lo_o
);

  hilo_t hi_q;
  hilo_t lo_q;

  // Commit HI/LO together; async clear on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= ZERO_WORD;
      lo_q <= ZERO_WORD;
    end else if (we == WRITE_ENABLE) begin
      hi_q <= hi;
      lo_q <= lo;
    end
  end

  // Bypass the in-flight write; force zero while in reset.
  always_comb begin
    hi_o = ZERO_WORD;
    lo_o = ZERO_WORD;
    if (rst) begin
      hi_o = we ? hi : hi_q;
      lo_o = we ? lo : lo_q;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback register file: 32x64 GPRs, HI/LO, two bypassed read ports.
// Optional WB_RETIRE_CNT_EN adds a 32-bit retired-write counter port.
module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
`ifdef WB_RETIRE_CNT_EN
  output logic [31:0] wb_retire_cnt,
`endif
  input  reg_addr_t wb_wd,
  input  logic      wb_wreg,
  input  reg_t      wb_wdata,
  input  hilo_t     wb_hi,
  input  hilo_t     wb_lo,
  input  logic      wb_whilo,
  input  logic      re1,
  input  reg_addr_t raddr1,
  output reg_t      rdata1,
  input  logic      re2,
  input  reg_addr_t raddr2,
  output reg_t      rdata2,
  output hilo_t     hi_o,
  output hilo_t     lo_o
);

  reg_t regs [NREG];
  logic gpr_we;

  assign gpr_we = (wb_wreg == WRITE_ENABLE) && (wb_wd != NOP_REG_ADDR);

  // GPR commit; register 0 is never written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= ZERO_DWORD;
    end else if (gpr_we) begin
      regs[wb_wd] <= wb_wdata;
    end
  end

  function automatic reg_t rd_port(
    input logic      rst_n,
    input logic      re,
    input reg_addr_t addr,
    input logic      wreg,
    input reg_addr_t wd,
    input reg_t      wdata,
    input reg_t      stored
  );
    if (!rst_n || re != READ_ENABLE) return ZERO_DWORD;
    if (addr == NOP_REG_ADDR) return ZERO_DWORD;
    if (wreg && wd == addr) return wdata;
    return stored;
  endfunction

  // Read port 1: enable, r0, bypass, then array.
  always_comb begin
    rdata1 = ZERO_DWORD;
    rdata1 = rd_port(rst, re1, raddr1, wb_wreg, wb_wd,
                     wb_wdata, regs[raddr1]);
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    rdata2 = ZERO_DWORD;
    rdata2 = rd_port(rst, re2, raddr2, wb_wreg, wb_wd,
                     wb_wdata, regs[raddr2]);
  end

  hilo_reg u_hilo (
    .clk  (clk),
    .rst  (rst),
    .we   (wb_whilo),
    .hi   (wb_hi),
    .lo   (wb_lo),
    .hi_o (hi_o),
    .lo_o (lo_o)
  );

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] cnt_q;

  // Count cycles retiring any write; GPR+HI/LO counts once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (gpr_we || wb_whilo) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign wb_retire_cnt = cnt_q;
`endif

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
Writeback-side consumer of the MEM/WB pipeline register.
- Holds the 32 x 64-bit general register file and the 32-bit HI/LO pair.
- Commits the wb_* write fields on the clock edge.
- Serves two combinational read ports to the decode stage, with same-cycle writeback bypass. This avoids a read-after-write hazard on an instruction retiring in WB.

Parameters:
- XLEN, 64, general register data width
- NREG, 32, number of general registers; register 0 hardwired to zero
- ADDR_W, 5, register address width; matches `RegAddrBus
- HILO_W, 32, width of each of HI and LO

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- wb_wd  input  ADDR_W  destination register address from MEM/WB
- wb_wreg  input  1  register write enable from MEM/WB
- wb_wdata  input  XLEN  register write data from MEM/WB
- wb_hi  input  HILO_W  HI write value
- wb_lo  input  HILO_W  LO write value
- wb_whilo  input  1  HI/LO write enable
- re1  input  1  read enable, port 1
- raddr1  input  ADDR_W  read address, port 1
- rdata1  output  XLEN  read data, port 1
- re2  input  1  read enable, port 2
- raddr2  input  ADDR_W  read address, port 2
- rdata2  output  XLEN  read data, port 2
- hi_o  output  HILO_W  current HI, bypassed
- lo_o  output  HILO_W  current LO, bypassed

Behaviour:
- Reset (rst=0, asynchronous assert, synchronous release on the next clk edge):
  - all NREG registers and HI/LO clear to 0.
  - rdata1, rdata2, hi_o, lo_o drive 0 while rst=0.
  - writes presented during reset are discarded.
- Register write, rising clk with rst=1:
  - if wb_wreg=1 and wb_wd!=0, then reg[wb_wd] <= wb_wdata.
  - a write to address 0 is silently dropped; reg[0] stays 0 forever.
- HI/LO write, rising clk with rst=1: if wb_whilo=1, HI <= wb_hi and LO <= wb_lo, updated together and never independently.
- Read port n (n=1,2), purely combinational, zero-cycle latency. Priority order:
  1. re_n=0 -> rdata_n=0.
  2. raddr_n=0 -> rdata_n=0, even if a bypass write targets 0.
  3. wb_wreg=1 and wb_wd==raddr_n -> rdata_n=wb_wdata (bypass).
  4. otherwise rdata_n=reg[raddr_n].
- Both ports may read the same address at once, including the bypassed address; both see the same value.
- hi_o/lo_o: if wb_whilo=1 they show wb_hi/wb_lo (bypass), else the stored HI/LO.
- MEM/WB stall/flush bubbles arrive as wb_wreg=0 and wb_whilo=0, so no stall input is needed.
- Reset asserted mid-cycle: the state clears immediately; any write in flight that cycle is lost.
- The write data carries no byte enables; the full XLEN word is always written.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined:
  - adds output port wb_retire_cnt [31:0];
  - a counter increments by 1 on each rising clk with rst=1 where (wb_wreg=1 and wb_wd!=0) or wb_whilo=1;
  - a cycle where both are true counts once;
  - wraps 0xFFFFFFFF -> 0;
  - clears to 0 on reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared defines header: `RegAddrBus, `RegBus (63:0), `ZeroDWord, `ZeroWord, `WriteEnable, `WriteDisable, `ReadEnable, `NOPRegAddr.
- One natural sub-module, hilo_reg:
  - HI/LO storage, write enable and bypass mux;
  - instantiated once inside wb_regfile;
  - the GPR array and read muxes stay in the top module.

Test Plan:
- Reset: hold rst=0 with wb_wreg=1, wb_wd=5, wb_wdata=0xDEAD for 3 cycles, then release and read raddr1=5, re1=1 -> rdata1=0, hi_o=lo_o=0.
- Write then read: write reg3=0x0123_4567_89AB_CDEF, next cycle read raddr1=3, raddr2=3 -> both ports return 0x0123456789ABCDEF.
- Bypass: in the same cycle as wb_wreg=1, wb_wd=7, wb_wdata=0x55 (reg7 holds 0x11), read raddr2=7 -> rdata2=0x55 that cycle and 0x55 from the stored value the next cycle.
- Register 0: write wb_wd=0, wb_wdata=0xFFFF, read raddr1=0 in the same and next cycle -> rdata1=0 both times. With re1=0 and raddr1=3 -> rdata1=0.
- HI/LO: wb_whilo=1, wb_hi=0xAAAA0000, wb_lo=0x0000BBBB -> hi_o/lo_o show them that cycle and retain them after wb_whilo=0. Then assert rst=0 mid-cycle -> hi_o=lo_o=0 immediately.
- With WB_RETIRE_CNT_EN: 4 cycles with writes (one to reg0, one combined GPR+HI/LO), 2 idle cycles -> wb_retire_cnt=3. Preload 0xFFFFFFFF via forced count, one write -> 0.
